// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One radix-2 step per clock: shift-add for multiplies, restoring
// shift-subtract for divides. Operands are converted to magnitudes when a
// start is accepted, and the sign is restored on the final step.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [4:0]        rd_in,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [4:0]        rd_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  // Registered state.
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic                neg_q, neg_d;       // negate the final result
  logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;       // {hi, lo} product / {rem, quo}
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;

  // Datapath intermediates.
  logic                a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                is_div, div_zero, div_ovf;
  logic [XLEN-1:0]     fast_res;
  logic [XLEN-1:0]     mul_addend;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_nxt;
  logic [XLEN:0]       div_shift, div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   div_nxt;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;
  logic [XLEN-1:0]     calc_res;
  logic                accept;

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

  // Operand conditioning and the fast-path decision for a new request.
  always_comb begin
    is_div   = op[2];
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sign_a   = a_signed & rs1_val[XLEN-1];
    sign_b   = b_signed & rs2_val[XLEN-1];
    a_mag    = sign_a ? -rs1_val : rs1_val;
    b_mag    = sign_b ? -rs2_val : rs2_val;
    div_zero = is_div && (rs2_val == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    fast_res = '0;
    if (div_zero) begin
      fast_res = op[1] ? rs1_val : '1;
    end else if (div_ovf) begin
      fast_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration of each datapath plus the sign fix-up of the final step.
  always_comb begin
    mul_addend = acc_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    mul_nxt    = {mul_sum, acc_q[XLEN-1:1]};

    div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff   = div_shift - {1'b0, opnd_q};
    div_ge     = ~div_diff[XLEN];
    div_rem    = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_nxt    = {div_rem, acc_q[XLEN-2:0], div_ge};

    prod_fix   = neg_q ? -mul_nxt : mul_nxt;
    quo_fix    = neg_q ? -div_nxt[XLEN-1:0] : div_nxt[XLEN-1:0];
    rem_fix    = neg_q ? -div_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];

    case (op_q)
      OP_MUL:                       calc_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_res = quo_fix;
      OP_REM, OP_REMU:              calc_res = rem_fix;
      default:                      calc_res = '0;
    endcase
  end

  // Next-state logic: iterate, accept new requests, and honour kill.
  always_comb begin
    // NOTE: every signal gets a hold value first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    accept = start && !kill && (state_q != CALC);

    case (state_q)
      CALC: begin
        acc_d = op_q[2] ? div_nxt : mul_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          result_d = calc_res;
          rd_out_d = rd_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      op_d   = op;
      rd_d   = rd_in;
      cnt_d  = '0;
      // Quotient and product take the XOR of the signs; remainder follows the dividend.
      neg_d  = (is_div && op[1]) ? sign_a : (sign_a ^ sign_b);
      opnd_d = is_div ? b_mag : a_mag;
      acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      if (div_zero || div_ovf) begin
        state_d  = DONE;
        result_d = fast_res;
        rd_out_d = rd_in;
      end else begin
        state_d  = CALC;
      end
    end

    // Abort wins over everything, including a result load on the last step.
    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  // State register with asynchronous clear of every flop, accumulators included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit. Stimulus pushes the expected result,
// destination and done latency (posedges from the start edge to the edge
// that enters DONE) into a queue; a monitor pops and compares on every done.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .kill    (kill),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: result 0x%08h rd %0d with nothing outstanding", result, rd_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_result"}, result, e.res);
        check({e.tag, "_rd_out"}, 32'(rd_out), 32'(e.rd));
        check({e.tag, "_latency"}, cyc - e.start_edge, e.lat);
      end
    end
  end

  // Present a request; start is sampled on the next posedge.
  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op      = o;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
  endtask

  task automatic expect_op(input string tag, input logic [31:0] res, input logic [4:0] rd,
                           input int lat);
    exp_t e;
    e.tag        = tag;
    e.res        = res;
    e.rd         = rd;
    e.lat        = lat;
    e.start_edge = cyc + 1;
    sb_q.push_back(e);
    last_res = res;
    last_rd  = rd;
  endtask

  // Wait (bounded) for done, counting sampled cycles with busy high.
  task automatic wait_done(input string tag, input int exp_busy);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: done not seen within 40 cycles, required within 40", tag);
    end
    check({tag, "_busy_cycles"}, nb, exp_busy);
  endtask

  // Full operation; b2b issues in the current DONE cycle instead of after it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                        input bit fast, input bit b2b);
    if (!b2b) @(negedge clk);
    drive(o, a, b, rd);
    expect_op(tag, res, rd, fast ? 0 : 32);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(tag, fast ? 0 : 32);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", result,      32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Multiplies.
    run_op("mul",    OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1'b0, 1'b0);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mulh_neg", OP_MULH, 32'hFFFF_FFFF, 32'h0000_0002, 5'd22, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Divides, normal path.
    run_op("div",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("rem",    OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu",   OP_DIVU, 32'd100,       32'd7, 5'd11, 32'd14,        1'b0, 1'b0);
    run_op("remu",   OP_REMU, 32'd100,       32'd7, 5'd12, 32'd2,         1'b0, 1'b0);
    run_op("div_nb", OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd23, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("rem_nb", OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd24, 32'd1,         1'b0, 1'b0);

    // Fast paths: done in the cycle right after the start edge, busy never high.
    run_op("divu_z", OP_DIVU, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("rem_z",  OP_REM,  32'd5,         32'd0,         5'd14, 32'd5,         1'b1, 1'b0);
    run_op("div_ov", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1, 1'b0);
    run_op("rem_ov", OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b1, 1'b0);

    // A start in CALC (10 edges in) must be ignored.
    @(negedge clk);
    drive(OP_MUL, 32'd3, 32'd5, 5'd17);
    expect_op("mul_ign", 32'd15, 5'd17, 32);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    drive(OP_DIVU, 32'd9, 32'd3, 5'd18);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("mul_ign", 22);
    repeat (40) @(negedge clk);

    // Back-to-back: second start presented in the DONE cycle.
    run_op("b2b_mul",  OP_MUL,  32'h0000_1234, 32'h0000_0010, 5'd19, 32'h0001_2340, 1'b0, 1'b0);
    run_op("b2b_divu", OP_DIVU, 32'h1234_5678, 32'h0000_0100, 5'd20, 32'h0012_3456, 1'b0, 1'b1);

    // Kill on the 15th edge of a divide: no done, outputs keep the last result.
    @(negedge clk);
    @(negedge clk);
    drive(OP_DIVU, 32'd1000, 32'd3, 5'd21);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_busy_drop", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("kill_result_held", result,      last_res);
    check("kill_rd_held",     32'(rd_out), 32'(last_rd));

    // Asynchronous reset 20 edges into a multiply, between clock edges.
    @(negedge clk);
    drive(OP_MUL, 32'd11, 32'd13, 5'd25);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(busy),   32'd0);
    check("arst_done",   32'(done),   32'd0);
    check("arst_result", result,      32'd0);
    check("arst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_result_after", result, 32'd0);

    // Unit recovers after the reset.
    run_op("post_rst", OP_REMU, 32'd100, 32'd7, 5'd26, 32'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
